uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive side of the board UART (8N1, LSB first). Pairs with uart_tx on the same clk
//  (27 MHz crystal). Recovers bytes from the asynchronous RX pin and buffers them in a
//  small FIFO. The FIFO presents them to the consumer over a valid/ready handshake.
//  Flags framing errors and overruns.
// PARAMETERS
//  CLOCK_FREQUENCY  27000000                      clk frequency, Hz
//  BAUD_RATE        115200                        line rate, bit/s
//  BAUD_DIVISOR     CLOCK_FREQUENCY/BAUD_RATE     clk cycles per bit (234 at defaults); must be >= 8
//  FIFO_DEPTH       4                             receive buffer entries; power of two, >= 2
// PORTS
//  clk          in   1  system clock; all logic on its rising edge
//  rst_n        in   1  asynchronous reset, active-low
//  rx           in   1  serial input from pin; asynchronous, idles high
//  data         out  8  FIFO head byte; valid only while valid=1
//  valid        out  1  FIFO non-empty
//  ready        in   1  consumer accepts head; pop when valid && ready
//  frame_error  out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  overrun      out  1  1-cycle pulse: byte completed while FIFO full, byte discarded
//  busy         out  1  receiver FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): outputs and FIFO state
//  - FSM IDLE, both sync flops =1, FIFO empty
//  - valid=0, data=8'h00, frame_error=0, overrun=0, busy=0
//  Reset mid-frame aborts the frame. A partial byte is never delivered.
//  Input path: rx passes through a 2-flop synchronizer (rx_s). An edge detector on rx_s
//  uses its previous value.
//  Bit counter: width $clog2(BAUD_DIVISOR), counts 0..BAUD_DIVISOR-1, then wraps to 0.
//  FSM states
//  - IDLE: on a falling edge of rx_s -> START, counter=0. A line held low never retriggers.
//  - START: at count BAUD_DIVISOR/2-1, sample rx_s.
//      If 0 -> DATA, counter=0, bit_idx=0.
//      If 1 -> IDLE. This is a glitch; no flag is raised.
//  - DATA: during counts D-3, D-2, D-1 (D=BAUD_DIVISOR), take three rx_s samples.
//      At D-1, shift the 2-of-3 majority into shift_reg[7] (right shift; LSB first).
//      After bit_idx==7 -> STOP; otherwise bit_idx+1.
//  - STOP: majority sample taken the same way.
//      If 1: push shift_reg into the FIFO, or pulse overrun if the FIFO is full.
//      If 0: pulse frame_error and drop the byte.
//      Both cases -> IDLE on the same edge.
//  Latency: valid rises 1 clk after the STOP decision edge when the FIFO was empty.
//  That is about 9.5 bit times plus 2 sync cycles after the start edge.
//  FIFO: circular buffer, rd/wr pointers with one extra wrap bit.
//  - data = mem[rd_ptr], registered-read-free.
//  - Pop on valid && ready. A pop while empty is ignored.
//  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
//  - Push and pop in the same cycle while empty: push only. valid rises next cycle.
//  - Ordering is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
//  frame_error and overrun never pulse in the same cycle; at most one per frame.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//  - CLOCK_FREQUENCY/BAUD_RATE defaults (shared with uart_tx)
//  - FSM state encodings (IDLE/START/DATA/STOP)
//  - 8N1 frame constants
//  Sub-module uart_rx_fifo (params WIDTH=8, DEPTH): push/full, pop/empty, dout.
//  The top level holds the synchronizer, counter, FSM, majority vote, shift register
//  and flag pulses.
// TESTING
//  - Byte 0x55 at 234 clk/bit, ready=1 -> valid for exactly 1 clk, data=0x55,
//    no flags, busy falls after STOP.
//  - rx low 50 clk then high -> no valid, no flags, busy=1 during START only,
//    FSM back in IDLE.
//  - Byte 0xA3 with stop bit 0 -> frame_error pulse, no valid.
//    Then hold rx low 3 bit times, release, send 0x12 -> data=0x12, valid.
//  - ready=0, send 0x01..0x05 -> overrun pulse on the 5th byte.
//    Then ready=1 pops 01,02,03,04 in order. Also: full FIFO with pop on the push edge
//    -> no overrun, byte retained.
//  - Loopback from uart_tx sending "tuss\r\n" -> 74 75 73 73 0D 0A received in order.
//  - rst_n pulsed low during data bit 3 -> outputs at reset values.
//    That byte is never delivered; next byte 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: line defaults, frame constants,
// FSM state encoding and the majority-vote helper.
package uart_rx_pkg;

  localparam int unsigned CLOCK_FREQUENCY_DEF = 32'd27000000;
  localparam int unsigned BAUD_RATE_DEF       = 32'd115200;

  localparam int unsigned DATA_BITS   = 32'd8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: circular FIFO with wrap-bit pointers and an unregistered head output.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, bit timing, majority-voted sampling FSM,
// and a small receive FIFO with valid/ready output plus framing/overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEF,
  parameter int unsigned BAUD_RATE       = BAUD_RATE_DEF,
  parameter int unsigned BAUD_DIVISOR    = CLOCK_FREQUENCY / BAUD_RATE,
  parameter int unsigned FIFO_DEPTH      = 32'd4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(BAUD_DIVISOR);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIVISOR / 32'd2 - 32'd1);
  localparam logic [CW-1:0] CNT_S0   = CW'(BAUD_DIVISOR - 32'd3);
  localparam logic [CW-1:0] CNT_S1   = CW'(BAUD_DIVISOR - 32'd2);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIVISOR - 32'd1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 32'd1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;
  logic                 fall_s, vote_s, push_s, pop_s, fifo_full_s, fifo_empty_s;

  assign fall_s = rx_prev_q & ~rx_s_q;
  assign vote_s = maj3(samp_q[0], samp_q[1], rx_s_q);
  assign pop_s  = valid && ready;

  // Synchronizer, edge history and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= '0;
      samp_q        <= 2'b11;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync1_q       <= rx;
      rx_s_q        <= sync1_q;
      rx_prev_q     <= rx_s_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      samp_q        <= samp_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state logic: bit timing, sampling, shifting and the end-of-frame decision.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    samp_d        = samp_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    push_s        = 1'b0;

    if (cnt_q == CNT_S0) begin
      samp_d[0] = rx_s_q;
    end else if (cnt_q == CNT_S1) begin
      samp_d[1] = rx_s_q;
    end else begin
      samp_d = samp_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s_q == START_LEVEL) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          // A pop on this same edge frees the slot, so a full FIFO is not an overrun then.
          if (vote_s == STOP_LEVEL) begin
            if (fifo_full_s && !pop_s) begin
              overrun_d = 1'b1;
            end else begin
              push_s = 1'b1;
            end
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_s),
    .din_i  (shift_d),
    .pop_i  (pop_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s),
    .dout_o (data)
  );

  assign valid       = !fifo_empty_s;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 234 clk/bit: drives 8N1 frames on rx and
// checks delivered bytes, flag pulses, busy and reset behaviour.
module tb_uart_rx;

  localparam int BIT_CLKS = 234;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_log [0:255];
  int rx_n = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Monitor: log accepted bytes and count flag pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) valid_cycles++;
      if (valid && ready) begin
        rx_log[rx_n[7:0]] = data;
        rx_n++;
      end
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_error && overrun) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BIT_CLKS);
    end
    rx = stop;
    tick(BIT_CLKS);
  endtask

  initial begin
    int base;
    int fe0;
    int ov0;
    int v0;
    logic [7:0] tuss [6];
    logic [7:0] part;
    tuss[0] = 8'h74; tuss[1] = 8'h75; tuss[2] = 8'h73;
    tuss[3] = 8'h73; tuss[4] = 8'h0D; tuss[5] = 8'h0A;

    rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
    tick(5);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // single byte with consumer always ready
    ready = 1'b1;
    base = rx_n; v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h55, 1'b1);
    tick(20);
    check("b55_count", 32'(rx_n - base), 32'd1);
    check("b55_data", 32'(rx_log[base[7:0]]), 32'h55);
    check("b55_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("b55_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    check("b55_busy_after", 32'(busy), 32'd0);

    // start-bit glitch
    base = rx_n; fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    tick(20);
    check("glitch_busy_start", 32'(busy), 32'd1);
    tick(30);
    rx = 1'b1;
    tick(200);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_no_byte", 32'(rx_n - base), 32'd0);
    check("glitch_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // framing error, then a held-low line, then a good byte
    base = rx_n; fe0 = fe_cnt;
    send_byte(8'hA3, 1'b0);
    tick(BIT_CLKS);
    check("hold_low_idle", 32'(busy), 32'd0);
    tick(2 * BIT_CLKS);
    check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_no_byte", 32'(rx_n - base), 32'd0);
    rx = 1'b1;
    tick(BIT_CLKS);
    send_byte(8'h12, 1'b1);
    tick(20);
    check("b12_count", 32'(rx_n - base), 32'd1);
    check("b12_data", 32'(rx_log[base[7:0]]), 32'h12);

    // overrun on the fifth byte with the consumer stalled
    ready = 1'b0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    tick(20);
    check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("ovr_head_valid", 32'(valid), 32'd1);
    check("ovr_head_data", 32'(data), 32'h01);
    base = rx_n;
    ready = 1'b1;
    tick(10);
    ready = 1'b0;
    check("ovr_drain_count", 32'(rx_n - base), 32'd4);
    for (int i = 0; i < 4; i++) check("ovr_drain_data", 32'(rx_log[8'(base + i)]), 32'(i + 1));

    // full FIFO popped on the very edge the next byte is pushed
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b1);
    base = rx_n; ov0 = ov_cnt;
    fork
      send_byte(8'h15, 1'b1);
      begin
        tick(2225);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(20);
    check("fullpop_no_ovr", 32'(ov_cnt - ov0), 32'd0);
    check("fullpop_one_pop", 32'(rx_n - base), 32'd1);
    check("fullpop_popped", 32'(rx_log[base[7:0]]), 32'h11);
    ready = 1'b1;
    tick(10);
    check("fullpop_drain_count", 32'(rx_n - base), 32'd5);
    for (int i = 1; i < 5; i++) check("fullpop_drain_data", 32'(rx_log[8'(base + i)]), 32'(8'h11 + i));

    // back-to-back text stream
    base = rx_n;
    for (int i = 0; i < 6; i++) send_byte(tuss[i], 1'b1);
    tick(20);
    check("tuss_count", 32'(rx_n - base), 32'd6);
    for (int i = 0; i < 6; i++) check("tuss_data", 32'(rx_log[8'(base + i)]), 32'(tuss[i]));

    // reset in the middle of data bit 3
    ready = 1'b0;
    send_byte(8'h5A, 1'b1);
    tick(5);
    check("pre_rst_valid", 32'(valid), 32'd1);
    check("pre_rst_data", 32'(data), 32'h5A);
    part = 8'h3C;
    rx = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      tick(BIT_CLKS);
    end
    rx = part[3];
    tick(BIT_CLKS / 2);
    check("mid_rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(3);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_flags", 32'({frame_error, overrun}), 32'd0);
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3 * BIT_CLKS);
    base = rx_n;
    ready = 1'b1;
    send_byte(8'hC3, 1'b1);
    tick(20);
    check("post_rst_count", 32'(rx_n - base), 32'd1);
    check("post_rst_data", 32'(rx_log[base[7:0]]), 32'hC3);
    check("no_dual_flags", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
